hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 41 ++++
 rtl/hazard_scoreboard_reg_use_decode.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 104 ++++++++++
 tb/tb_hazard_scoreboard.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared processor constants: opcode/funct encodings, issue latency and the
// pending-count threshold that forces an ID-stage stall.
package hazard_scoreboard_pkg;

  // Cycles from issue until the result is readable in ID (write-then-read RF).
  localparam int unsigned IssueCnt    = 3;
  // A source whose countdown is at or above this value is not yet readable.
  localparam int unsigned StallThresh = 2;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpRegimm  = 6'b000001;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] OpBlez    = 6'b000110;
  localparam logic [5:0] OpBgtz    = 6'b000111;
  localparam logic [5:0] OpAddi    = 6'b001000;
  localparam logic [5:0] OpAndi    = 6'b001100;
  localparam logic [5:0] OpOri     = 6'b001101;
  localparam logic [5:0] OpXori    = 6'b001110;
  localparam logic [5:0] OpLb      = 6'b100000;
  localparam logic [5:0] OpLh      = 6'b100001;
  localparam logic [5:0] OpLw      = 6'b100011;
  localparam logic [5:0] OpSb      = 6'b101000;
  localparam logic [5:0] OpSh      = 6'b101001;
  localparam logic [5:0] OpSw      = 6'b101011;

  localparam logic [5:0] FnJr      = 6'b001000;

  // Link register written by jal.
  localparam logic [4:0] RegRa     = 5'd31;

  typedef struct packed {
    logic       use_rs;
    logic       use_rt;
    logic       wr_en;
    logic [4:0] wr_reg;
  } reg_use_t;

endpackage

// File: rtl/hazard_scoreboard_reg_use_decode.sv
// Register-usage decoder: which source fields an instruction reads and which
// register (if any) it writes.
module reg_use_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic [4:0] Rt,
  input  logic [4:0] Rd,
  output logic       UseRs,
  output logic       UseRt,
  output logic       WrEn,
  output logic [4:0] WrReg
);

  reg_use_t dec;

  // Decode opcode class into source usage and destination.
  always_comb begin
    dec = '0;
    unique case (Opcode)
      OpSpecial: begin
        dec.use_rs = 1'b1;
        if (Funct != FnJr) begin
          dec.use_rt = 1'b1;
          dec.wr_en  = 1'b1;
          dec.wr_reg = Rd;
        end
      end
      OpAddi, OpAndi, OpOri, OpXori, OpLw, OpLb, OpLh: begin
        dec.use_rs = 1'b1;
        dec.wr_en  = 1'b1;
        dec.wr_reg = Rt;
      end
      OpSw, OpSb, OpSh, OpBeq, OpBne: begin
        dec.use_rs = 1'b1;
        dec.use_rt = 1'b1;
      end
      OpRegimm, OpBlez, OpBgtz: begin
        dec.use_rs = 1'b1;
      end
      OpJal: begin
        dec.wr_en  = 1'b1;
        dec.wr_reg = RegRa;
      end
      default: ;
    endcase
  end

  assign UseRs = dec.use_rs;
  assign UseRt = dec.use_rt;
  assign WrEn  = dec.wr_en;
  assign WrReg = dec.wr_reg;

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for RAW hazard detection in ID. Stalls the
// front end while any used source is still in flight, and counts stall cycles.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned ISSUE_CNT = IssueCnt,
  parameter int unsigned STALL_CW  = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [31:0]         Instruction,
  input  logic                IDValid,
  input  logic                Flush,
  output logic                Stall,
  output logic                PCWrite,
  output logic                IFIDWrite,
  output logic                IDEXBubble,
  output logic                IFIDFlush,
  output logic [STALL_CW-1:0] StallCount
);

  localparam int unsigned PendW = ISSUE_CNT;

  logic [NUM_REGS-1:0][PendW-1:0] pend_q, pend_d;
  logic [STALL_CW-1:0]            cnt_q, cnt_d;

  logic [4:0] rs, rt;
  logic       use_rs, use_rt, wr_en;
  logic       rs_busy, rt_busy;
  logic [4:0] wr_reg;
  logic       issue;
  logic       unused_shamt;

  assign rs           = Instruction[25:21];
  assign rt           = Instruction[20:16];
  assign unused_shamt = ^Instruction[10:6];

  reg_use_decode u_reg_use_decode (
    .Opcode (Instruction[31:26]),
    .Funct  (Instruction[5:0]),
    .Rt     (rt),
    .Rd     (Instruction[15:11]),
    .UseRs  (use_rs),
    .UseRt  (use_rt),
    .WrEn   (wr_en),
    .WrReg  (wr_reg)
  );

  // A used, nonzero source with countdown >= threshold is not yet readable.
  always_comb begin
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    if (use_rs && (rs != '0) && (32'(rs) < NUM_REGS)) begin
      rs_busy = (pend_q[rs] >= PendW'(StallThresh));
    end
    if (use_rt && (rt != '0) && (32'(rt) < NUM_REGS)) begin
      rt_busy = (pend_q[rt] >= PendW'(StallThresh));
    end
  end

  // Rst gates Stall directly so a mid-stall reset drops it without an edge.
  assign Stall      = ~Rst & IDValid & ~Flush & (rs_busy | rt_busy);
  assign PCWrite    = ~Stall;
  assign IFIDWrite  = ~Stall;
  assign IDEXBubble = Stall | Flush;
  assign IFIDFlush  = Flush;
  assign StallCount = cnt_q;

  assign issue = IDValid & ~Flush & ~Stall;

  // Countdowns decrement every edge; an issuing writer reloads its destination.
  always_comb begin
    pend_d = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PendW'(1);
      end
      if (issue && wr_en && (wr_reg != '0) && (32'(wr_reg) == r)) begin
        pend_d[r] = PendW'(ISSUE_CNT);
      end
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    cnt_d = cnt_q;
    if (Stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + STALL_CW'(1);
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a behavioural scoreboard model
// predicts each cycle's outputs, plus scenario-level stall-count checks.
module tb_hazard_scoreboard;

  localparam int CW     = 4;
  localparam int CntMax = 15;

  logic          Clk;
  logic          Rst;
  logic [31:0]   Instruction;
  logic          IDValid;
  logic          Flush;
  logic          Stall;
  logic          PCWrite;
  logic          IFIDWrite;
  logic          IDEXBubble;
  logic          IFIDFlush;
  logic [CW-1:0] StallCount;

  int n_cmp  = 0;
  int n_fail = 0;

  int pend_m [32];
  int cnt_m;
  logic [8:0] exp_q [$];

  hazard_scoreboard #(
    .NUM_REGS  (32),
    .ISSUE_CNT (3),
    .STALL_CW  (CW)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .IDValid     (IDValid),
    .Flush       (Flush),
    .Stall       (Stall),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .IDEXBubble  (IDEXBubble),
    .IFIDFlush   (IFIDFlush),
    .StallCount  (StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction encoders
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
  endfunction

  function automatic logic [31:0] jr(input logic [4:0] rs);
    return {6'b000000, rs, 15'd0, 6'b001000};
  endfunction

  function automatic logic [31:0] jal();
    return {6'b000011, 26'h40};
  endfunction

  // Reference decode straight from the opcode table.
  function automatic void m_decode(input logic [31:0] ins, output bit ur, output bit ut,
                                   output bit we, output int wr);
    ur = 0; ut = 0; we = 0; wr = 0;
    case (ins[31:26])
      6'b000000: begin
        ur = 1;
        if (ins[5:0] != 6'b001000) begin ut = 1; we = 1; wr = int'(ins[15:11]); end
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b100011, 6'b100000, 6'b100001: begin
        ur = 1; we = 1; wr = int'(ins[20:16]);
      end
      6'b101011, 6'b101000, 6'b101001, 6'b000100, 6'b000101: begin ur = 1; ut = 1; end
      6'b000001, 6'b000110, 6'b000111: ur = 1;
      6'b000011: begin we = 1; wr = 31; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 0;
    cnt_m = 0;
  endtask

  // One ID cycle: predict, push, sample, pop/compare, then advance the model.
  task automatic step(input logic [31:0] ins, input logic v, input logic f,
                      input string name, output logic obs_stall);
    bit ur, ut, we;
    int wr, s, t;
    logic ms;
    logic [8:0] e, o;
    @(negedge Clk);
    Instruction = ins;
    IDValid     = v;
    Flush       = f;
    m_decode(ins, ur, ut, we, wr);
    s  = int'(ins[25:21]);
    t  = int'(ins[20:16]);
    ms = v && !f && ((ur && s != 0 && pend_m[s] >= 2) || (ut && t != 0 && pend_m[t] >= 2));
    exp_q.push_back({ms, !ms, !ms, ms | f, f, CW'(cnt_m)});
    #1;
    o = {Stall, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCount};
    e = exp_q.pop_front();
    n_cmp++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got {stall,pcw,ifidw,bub,iff,cnt}=%b required %b", name, o, e);
    end
    obs_stall = Stall;
    @(posedge Clk);
    for (int r = 1; r < 32; r++) if (pend_m[r] > 0) pend_m[r]--;
    if (v && !f && !ms && we && wr != 0) pend_m[wr] = 3;
    if (ms && cnt_m < CntMax) cnt_m++;
  endtask

  // Present the same instruction until the DUT stops stalling.
  task automatic issue_until(input logic [31:0] ins, input string name, output int stalls);
    logic s;
    bit issued;
    stalls = 0;
    issued = 0;
    for (int k = 0; k < 8; k++) begin
      step(ins, 1'b1, 1'b0, name, s);
      if (s !== 1'b1) begin issued = 1; break; end
      stalls++;
    end
    n_cmp++;
    if (!issued) begin
      n_fail++;
      $display("FAIL %s_timeout: still stalled after %0d cycles, required issue", name, stalls);
    end
  endtask

  task automatic drain();
    logic s;
    for (int k = 0; k < 4; k++) step(32'h0, 1'b0, 1'b0, "drain", s);
  endtask

  task automatic check_stalls(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: stall cycles %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; IDValid = 1'b1; Flush = 1'b1; Instruction = r_add(5'd2, 5'd1, 5'd3);
    model_reset();
    #13;
    n_cmp++;
    if ({Stall, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCount} !== {5'b01111, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b%b%b%b%b cnt=%0d required 01111 cnt=0",
               Stall, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, StallCount);
    end
    @(negedge Clk);
    IDValid = 1'b0; Flush = 1'b0;
    Rst = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    logic s;
    int n;
    step(i_op(6'b001000, 5'd0, 5'd1), 1'b1, 1'b0, "b2b_addi", s);
    issue_until(r_add(5'd2, 5'd1, 5'd3), "b2b_add", n);
    check_stalls("b2b_stalls", n, 2);
    n_cmp++;
    if (StallCount !== CW'(2)) begin
      n_fail++;
      $display("FAIL b2b_count: StallCount %0d required 2", StallCount);
    end
    drain();
  endtask

  task automatic test_gap();
    logic s;
    int n;
    step(i_op(6'b001000, 5'd0, 5'd1), 1'b1, 1'b0, "gap_prod", s);
    step(r_add(5'd10, 5'd11, 5'd12), 1'b1, 1'b0, "gap_ind1", s);
    step(i_op(6'b001101, 5'd13, 5'd14), 1'b1, 1'b0, "gap_ind2", s);
    issue_until(r_add(5'd2, 5'd1, 5'd1), "gap_cons", n);
    check_stalls("gap_stalls", n, 0);
    step(i_op(6'b001000, 5'd0, 5'd6), 1'b1, 1'b0, "gap1_prod", s);
    step(r_add(5'd10, 5'd11, 5'd12), 1'b1, 1'b0, "gap1_ind", s);
    issue_until(r_add(5'd2, 5'd6, 5'd0), "gap1_cons", n);
    check_stalls("gap1_stalls", n, 1);
    drain();
  endtask

  task automatic test_store_zero();
    logic s;
    int n;
    step(i_op(6'b100011, 5'd6, 5'd5), 1'b1, 1'b0, "lw5", s);
    issue_until(i_op(6'b101011, 5'd6, 5'd5), "sw5", n);
    check_stalls("store_stalls", n, 2);
    drain();
    step(i_op(6'b001000, 5'd0, 5'd0), 1'b1, 1'b0, "addi0", s);
    issue_until(r_add(5'd4, 5'd0, 5'd0), "add_zero", n);
    check_stalls("zero_stalls", n, 0);
    drain();
  endtask

  task automatic test_flush();
    logic s;
    step(jal(), 1'b1, 1'b0, "jal", s);
    step(jr(5'd31), 1'b1, 1'b0, "jr_stall", s);
    n_cmp++;
    if (s !== 1'b1) begin n_fail++; $display("FAIL jr_stall1: Stall %b required 1", s); end
    step(jr(5'd31), 1'b1, 1'b1, "jr_flush", s);
    n_cmp++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL jr_flush: Stall %b required 0", s); end
    step(jr(5'd31), 1'b1, 1'b0, "jr_after", s);
    n_cmp++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL jr_after: Stall %b required 0", s); end
    drain();
    step(i_op(6'b001000, 5'd0, 5'd7), 1'b1, 1'b1, "flushed_prod", s);
    step(r_add(5'd8, 5'd7, 5'd7), 1'b1, 1'b0, "after_flushed", s);
    n_cmp++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL flushed_prod: Stall %b required 0", s); end
    drain();
  endtask

  task automatic test_waw();
    logic s;
    int n;
    step(i_op(6'b001000, 5'd0, 5'd1), 1'b1, 1'b0, "waw_a", s);
    step(i_op(6'b001000, 5'd2, 5'd1), 1'b1, 1'b0, "waw_b", s);
    issue_until(r_add(5'd3, 5'd1, 5'd0), "waw_cons", n);
    check_stalls("waw_stalls", n, 2);
    drain();
  endtask

  task automatic test_decode();
    logic [31:0] prod [7];
    logic [31:0] cons [7];
    int          req  [7];
    logic s;
    int n;
    prod[0] = i_op(6'b001000, 5'd0, 5'd1);  cons[0] = i_op(6'b000100, 5'd2, 5'd1);   req[0] = 2;
    prod[1] = i_op(6'b001101, 5'd0, 5'd1);  cons[1] = i_op(6'b000111, 5'd1, 5'd0);   req[1] = 2;
    prod[2] = i_op(6'b100000, 5'd0, 5'd1);  cons[2] = i_op(6'b000010, 5'd1, 5'd1);   req[2] = 0;
    prod[3] = i_op(6'b001000, 5'd0, 5'd1);  cons[3] = i_op(6'b111111, 5'd1, 5'd1);   req[3] = 0;
    prod[4] = i_op(6'b001100, 5'd0, 5'd1);  cons[4] = jr(5'd1);                      req[4] = 2;
    prod[5] = r_add(5'd3, 5'd2, 5'd2);      cons[5] = i_op(6'b101001, 5'd9, 5'd3);   req[5] = 2;
    prod[6] = i_op(6'b001110, 5'd0, 5'd1);  cons[6] = i_op(6'b001000, 5'd2, 5'd1);   req[6] = 0;
    for (int i = 0; i < 7; i++) begin
      step(prod[i], 1'b1, 1'b0, $sformatf("dec_prod%0d", i), s);
      issue_until(cons[i], $sformatf("dec_cons%0d", i), n);
      check_stalls($sformatf("dec_stalls%0d", i), n, req[i]);
      drain();
    end
  endtask

  task automatic test_rst_mid_stall();
    logic s;
    step(i_op(6'b001000, 5'd0, 5'd1), 1'b1, 1'b0, "rst_prod", s);
    @(negedge Clk);
    Instruction = r_add(5'd2, 5'd1, 5'd3);
    IDValid = 1'b1;
    Flush = 1'b0;
    #1;
    n_cmp++;
    if (Stall !== 1'b1) begin n_fail++; $display("FAIL rst_pre: Stall %b required 1", Stall); end
    Rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({Stall, PCWrite, StallCount} !== {2'b01, CW'(0)}) begin
      n_fail++;
      $display("FAIL rst_async: Stall %b PCWrite %b cnt %0d required 0 1 0",
               Stall, PCWrite, StallCount);
    end
    @(negedge Clk);
    IDValid = 1'b0;
    Rst = 1'b0;
    step(r_add(5'd2, 5'd1, 5'd3), 1'b1, 1'b0, "rst_after", s);
    n_cmp++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL rst_pend_clear: Stall %b required 0", s); end
    drain();
  endtask

  task automatic test_saturation();
    logic s;
    int n;
    for (int i = 0; i < 10; i++) begin
      step(i_op(6'b001000, 5'd0, 5'd1), 1'b1, 1'b0, "sat_prod", s);
      issue_until(r_add(5'd2, 5'd1, 5'd1), "sat_cons", n);
    end
    n_cmp++;
    if (StallCount !== CW'(CntMax)) begin
      n_fail++;
      $display("FAIL sat_count: StallCount %0d required %0d", StallCount, CntMax);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_store_zero();
    test_flush();
    test_waw();
    test_decode();
    test_rst_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
